// File: rtl/sargantana_multiway_ram_pkg.sv
// rtl/sargantana_multiway_ram_pkg.sv - shared types and helpers for the multi-way set RAM
// Purpose: FSM state encoding and the way-slice offset helper used by the top.
// Ports: none (package).
package sargantana_mway_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Bit offset of way `way` inside the flattened N_WAYS*WAY_WIDTH read bus.
    function automatic int way_offset(input int way, input int width);
        return way * width;
    endfunction

endpackage

// File: rtl/sargantana_multiway_ram_way_bank.sv
// rtl/sargantana_multiway_ram_way_bank.sv - one single-port way bank with byte writes
// Purpose: DEPTH x WAY_WIDTH storage for a single way; byte-granular write, registered read.
// Ports: clk_i, rstn_i (sync active-low, clears read register only), req_i, we_i,
//        be_i[BE_WIDTH], addr_i[ADDR_WIDTH], data_i[WAY_WIDTH] -> data_o[WAY_WIDTH] (registered).
module sargantana_way_bank #(
    parameter int DEPTH      = 64,
    parameter int WAY_WIDTH  = 256,
    parameter int BE_WIDTH   = WAY_WIDTH / 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WAY_WIDTH-1:0]  data_i,
    output logic [WAY_WIDTH-1:0]  data_o
);

    logic [WAY_WIDTH-1:0] r_mem [DEPTH];
    logic [WAY_WIDTH-1:0] r_data;

    // Storage itself has no reset; the top's clear sweep is what zeroes it.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (be_i[b]) begin
                    r_mem[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register holds its value on writes and idle cycles.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_data <= '0;
        end else if (req_i && !we_i) begin
            r_data <= r_mem[addr_i];
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/sargantana_multiway_ram.sv
// rtl/sargantana_multiway_ram.sv - N-way single-port set RAM with clear sweep
// Purpose: icache data/tag array; per-way write select, byte enables, read-valid strobe,
//          hardware clear sweep after reset and on flush.
// Ports: clk_i, rstn_i (sync active-low), req_i, we_i, way_we_i[N_WAYS], be_i[BE_WIDTH],
//        addr_i[ADDR_WIDTH], data_i[WAY_WIDTH], flush_i -> ready_o, busy_o, rvalid_o,
//        data_o[N_WAYS*WAY_WIDTH] (way w at [w*WAY_WIDTH +: WAY_WIDTH]).
module sargantana_multiway_ram
    import sargantana_mway_ram_pkg::*;
#(
    parameter int N_WAYS     = 4,
    parameter int DEPTH      = 64,
    parameter int WAY_WIDTH  = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BE_WIDTH   = WAY_WIDTH / 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [N_WAYS-1:0]           way_we_i,
    input  logic [BE_WIDTH-1:0]         be_i,
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    input  logic [WAY_WIDTH-1:0]        data_i,
    input  logic                        flush_i,
    output logic                        ready_o,
    output logic                        busy_o,
    output logic                        rvalid_o,
    output logic [N_WAYS*WAY_WIDTH-1:0] data_o
);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_rvalid;

    logic                  w_sweep;
    logic                  w_bank_we;
    logic [BE_WIDTH-1:0]   w_bank_be;
    logic [ADDR_WIDTH-1:0] w_bank_addr;
    logic [WAY_WIDTH-1:0]  w_bank_data;
    logic [N_WAYS-1:0]     w_bank_req;

    // Sweep writes one entry per cycle; the request side is muted while it runs,
    // including flush_i, so a sweep is never restarted mid-way.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state  <= ST_CLEAR;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    r_rvalid <= req_i && !we_i;
                    if (flush_i) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign w_sweep     = (r_state == ST_CLEAR);
    assign w_bank_we   = w_sweep | we_i;
    assign w_bank_be   = w_sweep ? {BE_WIDTH{1'b1}} : be_i;
    assign w_bank_addr = w_sweep ? r_cnt : addr_i;
    assign w_bank_data = w_sweep ? '0 : data_i;

    assign ready_o  = !w_sweep;
    assign busy_o   = w_sweep;
    assign rvalid_o = r_rvalid;

    // Reads enable every way; writes enable only the ways selected by way_we_i.
    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        assign w_bank_req[w] = w_sweep | (req_i & (!we_i | way_we_i[w]));

        sargantana_way_bank #(
            .DEPTH     (DEPTH),
            .WAY_WIDTH (WAY_WIDTH),
            .BE_WIDTH  (BE_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk_i (clk_i),
            .rstn_i(rstn_i),
            .req_i (w_bank_req[w]),
            .we_i  (w_bank_we),
            .be_i  (w_bank_be),
            .addr_i(w_bank_addr),
            .data_i(w_bank_data),
            .data_o(data_o[way_offset(w, WAY_WIDTH) +: WAY_WIDTH])
        );
    end

endmodule

// File: tb/tb_sargantana_multiway_ram.sv
// tb/tb_sargantana_multiway_ram.sv - directed self-checking bench for sargantana_multiway_ram
module tb_sargantana_multiway_ram;

    localparam logic [255:0]  P_A5   = {32{8'hA5}};
    localparam logic [255:0]  P_ONE  = {256{1'b1}};
    localparam logic [255:0]  P_LOW0 = {{28{8'hFF}}, 32'h0};
    localparam logic [255:0]  P_C    = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [31:0]   BE_ALL = 32'hFFFF_FFFF;
    localparam logic [1023:0] D0     = '0;
    localparam logic [1023:0] D5     = {256'h0, 256'h0, P_A5, 256'h0};
    localparam logic [1023:0] D7     = {4{P_LOW0}};
    localparam logic [1023:0] D9     = {P_C, 256'h0, 256'h0, P_C};

    logic          clk = 1'b0;
    logic          rstn;
    logic          req;
    logic          we;
    logic [3:0]    way_we;
    logic [31:0]   be;
    logic [5:0]    addr;
    logic [255:0]  wdata;
    logic          flush;
    logic          ready_o;
    logic          busy_o;
    logic          rvalid_o;
    logic [1023:0] data_o;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic          req;
        logic          we;
        logic [3:0]    ww;
        logic [31:0]   be;
        logic [5:0]    addr;
        logic [255:0]  wd;
        logic          exp_rv;
        logic [1023:0] exp_d;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    sargantana_multiway_ram dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .req_i   (req),
        .we_i    (we),
        .way_we_i(way_we),
        .be_i    (be),
        .addr_i  (addr),
        .data_i  (wdata),
        .flush_i (flush),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .rvalid_o(rvalid_o),
        .data_o  (data_o)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic exp_rv, input logic [1023:0] exp_d);
        chk({nm, " rvalid"}, 256'(rvalid_o), 256'(exp_rv));
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("%s way%0d", nm, w), data_o[w*256 +: 256], exp_d[w*256 +: 256]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 0; we = 0; way_we = 0; be = 0; addr = 0; wdata = 0; flush = 0;
    endtask

    task automatic rd(input logic [5:0] a);
        req = 1; we = 0; way_we = 0; be = 0; addr = a; wdata = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] ww, input logic [31:0] b,
                      input logic [255:0] d);
        req = 1; we = 1; way_we = ww; be = b; addr = a; wdata = d;
    endtask

    function automatic logic [255:0] fill_pat(input logic [5:0] a);
        return {32{2'b00, a}};
    endfunction

    // Counts posedges after reset release until busy_o drops.
    task automatic count_busy_after_reset(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy_o && n < 200);
        chk({nm, " busy cycles"}, 256'(n), 256'(64));
        chk({nm, " ready after sweep"}, 256'(ready_o), 256'(1));
    endtask

    task automatic read_all_zero(input string nm);
        for (int a = 0; a < 64; a++) begin
            rd(6'(a));
            step();
            chk_out($sformatf("%s a%0d", nm, a), 1'b1, D0);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int rv_seen;
        logic [1023:0] d_hold;

        vecs[0]  = '{1'b1, 1'b1, 4'b0010, BE_ALL,       6'd5, P_A5,  1'b0, D0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 32'h0,        6'd5, '0,    1'b1, D5};
        vecs[2]  = '{1'b1, 1'b1, 4'b1111, BE_ALL,       6'd7, P_ONE, 1'b0, D5};
        vecs[3]  = '{1'b1, 1'b1, 4'b1111, 32'h0000_000F, 6'd7, '0,    1'b0, D5};
        vecs[4]  = '{1'b1, 1'b0, 4'b0000, 32'h0,        6'd7, '0,    1'b1, D7};
        vecs[5]  = '{1'b1, 1'b1, 4'b1001, BE_ALL,       6'd9, P_C,   1'b0, D7};
        vecs[6]  = '{1'b1, 1'b0, 4'b0000, 32'h0,        6'd9, '0,    1'b1, D9};
        vecs[7]  = '{1'b0, 1'b0, 4'b0000, 32'h0,        6'd0, '0,    1'b0, D9};
        vecs[8]  = '{1'b1, 1'b1, 4'b0000, BE_ALL,       6'd9, P_ONE, 1'b0, D9};
        vecs[9]  = '{1'b1, 1'b1, 4'b1111, 32'h0,        6'd9, P_ONE, 1'b0, D9};
        vecs[10] = '{1'b1, 1'b0, 4'b0000, 32'h0,        6'd9, '0,    1'b1, D9};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 32'h0,        6'd5, '0,    1'b1, D5};

        // Reset state
        idle();
        rstn = 0;
        repeat (3) step();
        chk_out("reset", 1'b0, D0);
        chk("reset busy", 256'(busy_o), 256'(1));
        chk("reset ready", 256'(ready_o), 256'(0));
        rstn = 1;
        count_busy_after_reset("init");
        read_all_zero("init rd");

        // Table-driven directed vectors
        for (int i = 0; i < 12; i++) begin
            req = vecs[i].req; we = vecs[i].we; way_we = vecs[i].ww;
            be = vecs[i].be; addr = vecs[i].addr; wdata = vecs[i].wd; flush = 0;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_d);
        end
        idle();

        // Fill every entry, then flush with a same-cycle write and requests during the sweep
        for (int a = 0; a < 64; a++) begin
            wr(6'(a), 4'hF, BE_ALL, fill_pat(6'(a)));
            step();
        end
        rd(6'd63);
        step();
        d_hold = {4{fill_pat(6'd63)}};
        chk_out("fill rd63", 1'b1, d_hold);
        wr(6'd3, 4'hF, BE_ALL, P_ONE);
        flush = 1;
        step();
        flush = 0;
        rd(6'd5);
        n = 0;
        rv_seen = 0;
        while (busy_o && n < 200) begin
            n++;
            if (rvalid_o) rv_seen++;
            step();
        end
        chk("flush busy cycles", 256'(n), 256'(64));
        chk("flush rvalid during sweep", 256'(rv_seen), 256'(0));
        chk_out("flush data hold", 1'b0, d_hold);
        idle();
        read_all_zero("flush rd");

        // Reset in the middle of a sweep
        wr(6'd10, 4'hF, BE_ALL, P_C);
        step();
        rd(6'd10);
        step();
        chk_out("pre-reset rd10", 1'b1, {4{P_C}});
        idle();
        flush = 1;
        step();
        flush = 0;
        repeat (19) step();
        chk("mid sweep busy", 256'(busy_o), 256'(1));
        rstn = 0;
        rd(6'd10);
        step();
        chk_out("mid sweep reset", 1'b0, D0);
        rstn = 1;
        idle();
        count_busy_after_reset("resweep");
        rd(6'd10);
        step();
        chk_out("resweep rd10", 1'b1, D0);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
